// File: rtl/handshake_const_check.sv
// ---------------------------------------------------------------------------
// handshake_const_check
//
// Consumer end of a constant-generation dataflow path. Every token accepted
// on the input channel is compared against a fixed word. The 1-bit verdict
// (1 = match) is queued in a two-entry result buffer and offered on the
// output channel. Alongside the verdicts the block keeps saturating
// match/mismatch statistics, a sticky error flag, and a copy of the first
// word that failed the comparison.
//
// Ports
//   clk            : single clock, all state changes on its rising edge
//   rst            : synchronous, active-low reset
//   ins            : incoming data token
//   ins_valid      : a token is present on ins
//   ins_ready      : block can take a token (registered state only)
//   outs           : result token, 1 = match, 0 = mismatch
//   outs_valid     : a result token is present on outs
//   outs_ready     : downstream takes the result token
//   match_count    : saturating count of matching tokens accepted
//   mismatch_count : saturating count of mismatching tokens accepted
//   error          : sticky, set by the first mismatch since reset
//   first_bad      : value of the first mismatching token
// ---------------------------------------------------------------------------
module handshake_const_check #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter logic [31:0] EXPECTED    = 32'h6B8A8F0B,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  ins,
  input  logic                   ins_valid,
  output logic                   ins_ready,
  output logic                   outs,
  output logic                   outs_valid,
  input  logic                   outs_ready,
  output logic [COUNT_WIDTH-1:0] match_count,
  output logic [COUNT_WIDTH-1:0] mismatch_count,
  output logic                   error,
  output logic [DATA_WIDTH-1:0]  first_bad
);

  localparam logic [DATA_WIDTH-1:0]  EXP_WORD  = EXPECTED[DATA_WIDTH-1:0];
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};

  // Buffer occupancy doubles as the control state of the result buffer.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_t;

  occ_t                   occ_q, occ_d;
  logic                   head_q, head_d;
  logic                   tail_q, tail_d;
  logic [COUNT_WIDTH-1:0] matchCount_q, matchCount_d;
  logic [COUNT_WIDTH-1:0] mismatchCount_q, mismatchCount_d;
  logic                   error_q, error_d;
  logic [DATA_WIDTH-1:0]  firstBad_q, firstBad_d;

  logic push;
  logic pop;
  logic hit;

  // ins_ready comes straight from the occupancy register, so a pop while full
  // frees the slot only on the following cycle and no combinational path
  // exists from outs_ready to ins_ready.
  assign ins_ready  = (occ_q != OCC_FULL);
  assign outs_valid = (occ_q != OCC_EMPTY);
  assign outs       = outs_valid & head_q;

  assign push = ins_valid & ins_ready;
  assign pop  = outs_valid & outs_ready;
  assign hit  = (ins == EXP_WORD);

  // Result buffer next state. head_q is always the oldest verdict; tail_q is
  // only meaningful when full. A push and pop together can only happen with
  // one entry held, and then the new verdict simply replaces the head.
  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    unique case (occ_q)
      OCC_EMPTY: begin
        if (push) begin
          head_d = hit;
          occ_d  = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (push && pop) begin
          head_d = hit;
        end else if (push) begin
          tail_d = hit;
          occ_d  = OCC_FULL;
        end else if (pop) begin
          occ_d  = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        if (pop) begin
          head_d = tail_q;
          occ_d  = OCC_ONE;
        end
      end
      default: begin
        occ_d = OCC_EMPTY;
      end
    endcase
  end

  // Statistics and first-error capture. Counters stick at all-ones; the error
  // flag and captured word only change on the first mismatch after reset.
  always_comb begin
    matchCount_d    = matchCount_q;
    mismatchCount_d = mismatchCount_q;
    error_d         = error_q;
    firstBad_d      = firstBad_q;
    if (push) begin
      if (hit) begin
        if (matchCount_q != COUNT_MAX) begin
          matchCount_d = matchCount_q + COUNT_ONE;
        end
      end else begin
        if (mismatchCount_q != COUNT_MAX) begin
          mismatchCount_d = mismatchCount_q + COUNT_ONE;
        end
        if (!error_q) begin
          error_d    = 1'b1;
          firstBad_d = ins;
        end
      end
    end
  end

  // State registers. Reset wins over any handshake on the same edge, so
  // buffered verdicts are dropped and an offered token is not counted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      occ_q           <= OCC_EMPTY;
      head_q          <= 1'b0;
      tail_q          <= 1'b0;
      matchCount_q    <= '0;
      mismatchCount_q <= '0;
      error_q         <= 1'b0;
      firstBad_q      <= '0;
    end else begin
      occ_q           <= occ_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      matchCount_q    <= matchCount_d;
      mismatchCount_q <= mismatchCount_d;
      error_q         <= error_d;
      firstBad_q      <= firstBad_d;
    end
  end

  assign match_count    = matchCount_q;
  assign mismatch_count = mismatchCount_q;
  assign error          = error_q;
  assign first_bad      = firstBad_q;

endmodule

// File: tb/tb_handshake_const_check.sv
// ---------------------------------------------------------------------------
// tb_handshake_const_check
//
// Drives handshake_const_check (COUNT_WIDTH = 4 so saturation is reachable)
// with directed phases followed by random traffic. A queue holds the verdicts
// the checker owes downstream; a monitor compares the output channel and the
// statistics against a simple reference model every cycle.
// ---------------------------------------------------------------------------
module tb_handshake_const_check;

  localparam int unsigned DW       = 32;
  localparam int unsigned CW       = 4;
  localparam logic [31:0] EXP_WORD = 32'h6B8A8F0B;
  localparam int          SAT_MAX  = 15;

  logic          clk;
  logic          rst;
  logic [DW-1:0] ins;
  logic          ins_valid;
  logic          ins_ready;
  logic          outs;
  logic          outs_valid;
  logic          outs_ready;
  logic [CW-1:0] match_count;
  logic [CW-1:0] mismatch_count;
  logic          error;
  logic [DW-1:0] first_bad;

  handshake_const_check #(
    .DATA_WIDTH (DW),
    .EXPECTED   (EXP_WORD),
    .COUNT_WIDTH(CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ins           (ins),
    .ins_valid     (ins_valid),
    .ins_ready     (ins_ready),
    .outs          (outs),
    .outs_valid    (outs_valid),
    .outs_ready    (outs_ready),
    .match_count   (match_count),
    .mismatch_count(mismatch_count),
    .error         (error),
    .first_bad     (first_bad)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: verdicts owed downstream, oldest first, plus statistics.
  bit          expQ[$];
  int          modelMatch    = 0;
  int          modelMismatch = 0;
  bit          modelErr      = 1'b0;
  logic [31:0] modelFirstBad = 32'd0;

  // What the previous drive asked for, retired into the model one cycle later.
  bit          prevRst  = 1'b0;
  bit          prevAcc  = 1'b0;
  logic [31:0] prevData = 32'd0;

  bit monitorOn  = 1'b0;
  int checkCount = 0;
  int passCount  = 0;

  // Every comparison goes through here.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // One cycle of stimulus, applied just after the rising edge. First folds the
  // outcome of the previous edge into the model, then drives new inputs.
  task automatic applyStimulus(input logic v, input logic [31:0] d,
                               input logic ordy, input logic rn);
    @(posedge clk);
    #1;
    if (!prevRst) begin
      expQ.delete();
      modelMatch    = 0;
      modelMismatch = 0;
      modelErr      = 1'b0;
      modelFirstBad = 32'd0;
    end else if (prevAcc) begin
      expQ.push_back(prevData == EXP_WORD);
      if (prevData == EXP_WORD) begin
        if (modelMatch < SAT_MAX) modelMatch++;
      end else begin
        if (modelMismatch < SAT_MAX) modelMismatch++;
        if (!modelErr) begin
          modelErr      = 1'b1;
          modelFirstBad = prevData;
        end
      end
    end
    rst        = rn;
    ins_valid  = v;
    ins        = d;
    outs_ready = ordy;
    prevRst    = rn;
    prevData   = d;
    prevAcc    = v && (ins_ready === 1'b1) && rn;
  endtask

  // Offer one token until it is taken, within a bounded number of cycles.
  task automatic sendToken(input logic [31:0] d, input logic ordy);
    int n = 0;
    applyStimulus(1'b1, d, ordy, 1'b1);
    while (!prevAcc && n < 20) begin
      applyStimulus(1'b1, d, ordy, 1'b1);
      n++;
    end
    checkOutput("accept_in_budget", 32'(prevAcc), 32'd1);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'hFFFF_FFFF, 1'b1, 1'b1);
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
  endtask

  // Monitor: mid-cycle, compare the DUT against the model and retire a
  // verdict whenever the output handshake will complete on the next edge.
  always @(negedge clk) begin
    if (monitorOn) begin
      checkOutput("outs_valid", 32'(outs_valid), 32'(expQ.size() != 0));
      checkOutput("ins_ready", 32'(ins_ready), 32'(expQ.size() < 2));
      if (outs_valid === 1'b1 && expQ.size() != 0) begin
        checkOutput("outs", 32'(outs), 32'(expQ[0]));
      end
      checkOutput("match_count", 32'(match_count), 32'(modelMatch));
      checkOutput("mismatch_count", 32'(mismatch_count), 32'(modelMismatch));
      checkOutput("error", 32'(error), 32'(modelErr));
      checkOutput("first_bad", first_bad, modelFirstBad);
      if (outs_valid === 1'b1 && outs_ready === 1'b1 && expQ.size() != 0) begin
        void'(expQ.pop_front());
      end
    end
  end

  initial begin
    rst        = 1'b0;
    ins        = '0;
    ins_valid  = 1'b0;
    outs_ready = 1'b1;
    doReset();
    doReset();
    monitorOn = 1'b1;

    $display("[TB] phase: four matching tokens, free-flowing output");
    for (int i = 0; i < 4; i++) sendToken(EXP_WORD, 1'b1);
    idleCycles(3);

    $display("[TB] phase: mixed sequence and first-error capture");
    doReset();
    sendToken(EXP_WORD, 1'b1);
    sendToken(32'h0000_0001, 1'b1);
    sendToken(32'hDEAD_BEEF, 1'b1);
    sendToken(EXP_WORD, 1'b1);
    idleCycles(3);

    $display("[TB] phase: backpressure with three offered tokens");
    doReset();
    sendToken(EXP_WORD, 1'b0);
    sendToken(32'h0000_0005, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h0000_0007, 1'b0, 1'b1);
      checkOutput("third_token_stalled", 32'(prevAcc), 32'd0);
    end
    sendToken(32'h0000_0007, 1'b1);
    idleCycles(4);

    $display("[TB] phase: simultaneous push and pop at one entry");
    doReset();
    sendToken(32'h1234_5678, 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, (i % 3 == 0) ? 32'h0000_00AA : EXP_WORD, 1'b1, 1'b1);
      checkOutput("push_pop_accept", 32'(prevAcc), 32'd1);
    end
    idleCycles(3);

    $display("[TB] phase: match counter saturation");
    doReset();
    for (int i = 0; i < 20; i++) sendToken(EXP_WORD, 1'b1);
    idleCycles(3);

    $display("[TB] phase: reset with buffered results and error set");
    doReset();
    sendToken(32'h0000_0BAD, 1'b0);
    sendToken(EXP_WORD, 1'b0);
    applyStimulus(1'b1, EXP_WORD, 1'b0, 1'b0);
    idleCycles(2);
    sendToken(32'h0000_0C0C, 1'b0);
    applyStimulus(1'b1, EXP_WORD, 1'b1, 1'b0);
    idleCycles(2);

    $display("[TB] phase: random traffic");
    doReset();
    for (int i = 0; i < 600; i++) begin
      logic        v;
      logic        r;
      logic        rn;
      logic [31:0] d;
      v  = ($urandom_range(0, 3) != 0);
      r  = ($urandom_range(0, 9) < 7);
      rn = ($urandom_range(0, 99) != 0);
      d  = ($urandom_range(0, 1) == 1) ? EXP_WORD : 32'($urandom);
      applyStimulus(v, d, r, rn);
    end
    idleCycles(4);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
